// File: rtl/count_source_pkg.sv
// Shared constants for the input-side counters and the display FSM that
// consumes them.
package count_source_pkg;

    // Width of every count handed to the display FSM.
    localparam int CNT_W = 4;

    // Ceiling for the frequency accumulator; it sticks here instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_SAT = 4'hF;

    // Number of flops used to bring an asynchronous pin into the clk domain.
    localparam int SYNC_DEPTH = 2;

    // Add a single-bit increment to a count, holding at CNT_SAT once reached.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic inc);
        logic [CNT_W-1:0] w_sum;
        w_sum = a + {{(CNT_W-1){1'b0}}, inc};
        return (a == CNT_SAT) ? a : w_sum;
    endfunction

endpackage

// File: rtl/count_source_debouncer.sv
// Push-button conditioner: synchronizes the raw pin, requires the new level
// to be stable for DEBOUNCE_CYCLES before accepting it, and emits a
// one-cycle pulse on each accepted 0->1 transition.
module input_debouncer
    import count_source_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [SYNC_DEPTH-1:0] w_sync_next;
    logic                  w_synced;
    logic [CW-1:0]         r_cnt;
    logic                  r_level;
    logic                  r_press;

    // Next state of the synchronizer chain: stage 0 takes the pin, each
    // later stage takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_next[gi] = i_raw;
            end else begin : g_rest
                assign w_sync_next[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    assign w_synced = r_sync[SYNC_DEPTH-1];

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_next;
        end
    end

    // Stability counter and debounced level; a press pulse is registered on
    // the same edge the level rises so the consumer sees it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_synced;
                r_cnt   <= '0;
                r_press <= w_synced;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/count_source.sv
// Input-side counter block feeding the display FSM: a debounced button
// event counter (Count_CT) and a gated rising-edge counter for Sig_In
// (Count_F, refreshed once per GATE_CYCLES window with an F_Valid pulse).
module count_source
    import count_source_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GATE_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Btn_In,
    input  logic             Sig_In,
    input  logic             Clr_CT,
    output logic [CNT_W-1:0] Count_CT,
    output logic [CNT_W-1:0] Count_F,
    output logic             F_Valid
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

    logic                  w_press;
    logic [CNT_W-1:0]      r_count_ct;

    logic [SYNC_DEPTH-1:0] r_sig_sync;
    logic [SYNC_DEPTH-1:0] w_sig_sync_next;
    logic                  r_sig_d3;
    logic                  w_sig_edge;

    logic [TW-1:0]         r_timer;
    logic                  w_terminal;
    logic [CNT_W-1:0]      r_acc;
    logic [CNT_W-1:0]      w_acc_plus;
    logic [CNT_W-1:0]      r_count_f;
    logic                  r_f_valid;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (Btn_In),
        .o_press(w_press)
    );

    // Button event counter; a clear beats a simultaneous press.
    always_ff @(posedge clk) begin
        if (rst || Clr_CT) begin
            r_count_ct <= '0;
        end else if (w_press) begin
            r_count_ct <= r_count_ct + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sig_sync
            if (gi == 0) begin : g_first
                assign w_sig_sync_next[gi] = Sig_In;
            end else begin : g_rest
                assign w_sig_sync_next[gi] = r_sig_sync[gi-1];
            end
        end
    endgenerate

    // Sig_In synchronizer plus one extra flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_sync <= '0;
            r_sig_d3   <= 1'b0;
        end else begin
            r_sig_sync <= w_sig_sync_next;
            r_sig_d3   <= r_sig_sync[SYNC_DEPTH-1];
        end
    end

    assign w_sig_edge = r_sig_sync[SYNC_DEPTH-1] & ~r_sig_d3;
    assign w_terminal = (r_timer == TIMER_LAST);
    assign w_acc_plus = sat_add(r_acc, w_sig_edge);

    // Free-running gate timer; reset restarts the window.
    always_ff @(posedge clk) begin
        if (rst || w_terminal) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Edge accumulator and published result; an edge on the terminal cycle
    // is folded into the window that is closing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_count_f <= '0;
            r_f_valid <= 1'b0;
        end else if (w_terminal) begin
            r_acc     <= '0;
            r_count_f <= w_acc_plus;
            r_f_valid <= 1'b1;
        end else begin
            r_acc     <= w_acc_plus;
            r_f_valid <= 1'b0;
        end
    end

    assign Count_CT = r_count_ct;
    assign Count_F  = r_count_f;
    assign F_Valid  = r_f_valid;

endmodule
